// File: rtl/mem_port.sv
// ============================================================================
//  mem_port : memory access sequencer between the multicycle controller and a
//             single-port, variable-latency word memory.
//  Rev 1.0
// ============================================================================
`default_nettype none

module mem_port #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              IRWrite,
    input  logic              IorD,
    input  logic              MemoryWrite,
    input  logic [31:0]       pc,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       rs2,
    input  logic [2:0]        func3,
    output logic [31:0]       ir,
    output logic [31:0]       mdr,
    output logic              stall,
    output logic              done,
    output logic              misalign,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int                CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [31:0]       NOP    = 32'h0000_0013;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        ir_q, ir_d, mdr_q, mdr_d;
    logic               stall_q, stall_d, done_q, done_d;
    logic               misalign_q, misalign_d, bus_err_q, bus_err_d;
    logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic               is_fetch_q, is_fetch_d, is_load_q, is_load_d;
    logic [1:0]         lane_q, lane_d, size_q, size_d;
    logic               uns_q, uns_d;

    logic               req_store, req_load, req_fetch, req_any, aligned;
    logic [31:0]        req_addr;
    logic [1:0]         req_size;
    logic [31:0]        st_wdata;
    logic [3:0]         st_be;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_data;
    logic               unused_addr_hi;

    // Bits above the word-address window never reach the memory.
    assign unused_addr_hi = ^(req_addr >> (ADDR_W + 2));

    always_comb begin
        req_store = IorD & MemoryWrite;
        req_load  = IorD & ~MemoryWrite;
        req_fetch = IRWrite & ~IorD;
        req_any   = IorD | IRWrite;
        req_addr  = IorD ? alu_out : pc;
        req_size  = IorD ? func3[1:0] : 2'd2;

        case (req_size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~req_addr[0];
            default: aligned = (req_addr[1:0] == 2'b00);
        endcase

        case (req_size)
            2'd0: begin
                st_wdata = {4{rs2[7:0]}};
                st_be    = 4'b0001 << req_addr[1:0];
            end
            2'd1: begin
                st_wdata = {2{rs2[15:0]}};
                st_be    = 4'b0011 << req_addr[1:0];
            end
            default: begin
                st_wdata = rs2;
                st_be    = 4'b1111;
            end
        endcase

        case (lane_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (size_q)
            2'd0:    ld_data = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'd1:    ld_data = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        mdr_d       = mdr_q;
        done_d      = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        wait_d      = wait_q;
        is_fetch_d  = is_fetch_q;
        is_load_d   = is_load_q;
        lane_d      = lane_q;
        size_d      = size_q;
        uns_d       = uns_q;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (req_any) begin
                    if (aligned) begin
                        state_d     = BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_store;
                        mem_addr_d  = req_addr[ADDR_W+1:2];
                        mem_be_d    = req_store ? st_be : 4'b1111;
                        mem_wdata_d = req_store ? st_wdata : mem_wdata_q;
                        is_fetch_d  = req_fetch;
                        is_load_d   = req_load;
                        lane_d      = req_addr[1:0];
                        size_d      = req_size;
                        uns_d       = IorD & func3[2];
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            default: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    if (is_fetch_q) begin
                        ir_d = mem_rdata;
                    end else if (is_load_q) begin
                        mdr_d = ld_data;
                    end
                end else if ((TIMEOUT != 0) && (wait_q == TO_VAL)) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    bus_err_d = 1'b1;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
            end
        endcase

        stall_d = (state_d == BUSY);
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            ir_q        <= NOP;
            mdr_q       <= '0;
            stall_q     <= 1'b0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            wait_q      <= '0;
            is_fetch_q  <= 1'b0;
            is_load_q   <= 1'b0;
            lane_q      <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            mdr_q       <= mdr_d;
            stall_q     <= stall_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            wait_q      <= wait_d;
            is_fetch_q  <= is_fetch_d;
            is_load_q   <= is_load_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
        end
    end

    assign ir        = ir_q;
    assign mdr       = mdr_q;
    assign stall     = stall_q;
    assign done      = done_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

`default_nettype wire

// File: doc/mem_port.md
# mem_port

Memory access sequencer between the multicycle controller and a single-port, variable-latency word memory. It turns the controller's one-cycle fetch/load/store strobes into a held request/ready transaction. It latches the fetched instruction into the instruction register and the aligned, extended load data into the memory data register. While a transaction is outstanding it raises `stall`, which freezes the controller's state register.

## Interface
- `ADDR_W`, 16: memory word-address width; byte address bits [ADDR_W+1:2] are used.
- `TIMEOUT`, 255: maximum wait cycles for `mem_ready`. A value of 0 disables the timeout.
- `clk  in  1`: clock; all state updates on the rising edge.
- `clr_n  in  1`: reset. One clock; reset is synchronous and active-low.
- `IRWrite  in  1`: fetch strobe from controller.
- `IorD  in  1`: data-access strobe; read when `MemoryWrite`=0.
- `MemoryWrite  in  1`: store strobe; qualifies `IorD`.
- `pc  in  32`: fetch byte address.
- `alu_out  in  32`: load/store byte address.
- `rs2  in  32`: store data.
- `func3  in  3`: access size/sign, RV32I encoding.
- `ir  out  32`: instruction register.
- `mdr  out  32`: memory data register.
- `stall  out  1`: transaction outstanding.
- `done  out  1`: one-cycle completion pulse.
- `misalign  out  1`: one-cycle misaligned-access pulse.
- `bus_err  out  1`: one-cycle timeout pulse.
- `mem_req  out  1`: memory request, registered.
- `mem_we  out  1`: write enable.
- `mem_addr  out  ADDR_W`: word address.
- `mem_wdata  out  32`: lane-replicated write data.
- `mem_be  out  4`: byte enables. Reads always use 4'b1111.
- `mem_ready  in  1`: memory completion. For reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata  in  32`: read data.

## Operation
- **Request decode, in IDLE only.**
  - Store: `IorD & MemoryWrite`.
  - Load: `IorD & !MemoryWrite`.
  - Fetch: `IRWrite`, used only if no data access is requested. A simultaneous fetch is dropped.
  - Strobes seen outside IDLE are ignored.
- **Capture.** On an accepted request the block registers the kind, the address, `func3[1:0]`, `func3[2]` and `rs2`.
- **Alignment.**
  - Word (`func3[1:0]`=2): requires `addr[1:0]`=0.
  - Half (`func3[1:0]`=1): requires `addr[0]`=0.
  - Byte: always aligned.
  - Fetch: requires `pc[1:0]`=0.
  - On a misaligned request: no memory cycle, `misalign` pulses next cycle, `ir`/`mdr` are unchanged, and the state stays IDLE.
- **Store lanes.**
  - SB: `wdata` = {4{rs2[7:0]}}, `be` = 1 << `addr[1:0]`.
  - SH: `wdata` = {2{rs2[15:0]}}, `be` = 4'b0011 << `addr[1:0]`.
  - SW: `wdata` = `rs2`, `be` = 4'b1111.
- **Load extract.**
  - Byte: lane `addr[1:0]`. Half: lane `addr[1]`.
  - LB and LH sign-extend. LBU and LHU zero-extend.
  - `func3[1:0]`=3 is treated as word.
- **State machine.**
  - IDLE → BUSY on an aligned request.
  - BUSY → IDLE on `mem_ready`: write `ir` (fetch) or `mdr` (load), and pulse `done`.
  - BUSY → IDLE when the wait counter reaches `TIMEOUT` with `mem_ready` still low: pulse `bus_err`; `ir`/`mdr` are unchanged.
- **BUSY outputs.** `mem_req`=1, and `mem_addr`/`mem_we`/`mem_be`/`mem_wdata` are held stable for the whole transaction.
- **Wait counter.** Cleared on entry to BUSY, incremented on each BUSY cycle without `mem_ready`, and saturating.
- **`stall`** = (state == BUSY), registered.

## Timing
- **Reset values** (edge with `clr_n`=0):
  - state = IDLE, `ir` = 32'h00000013 (NOP), `mdr` = 0.
  - `mem_req`, `mem_we` = 0; `mem_be` = 0; `mem_addr` = 0; `mem_wdata` = 0.
  - `stall`, `done`, `misalign`, `bus_err` = 0; wait counter = 0.
- **Reset mid-transaction.** The transaction is abandoned and `mem_req` is low from the next cycle. No `ir`/`mdr` update and no `done`.
- **Minimum latency.**
  - Strobe sampled at edge t.
  - `mem_req`/`stall` high in cycle t+1.
  - `mem_ready`=1 in cycle t+1 → `ir`/`mdr` valid and `done`=1 in cycle t+2, with `stall`=0.
- **N-cycle memory.** `stall` is high for exactly N cycles, where N is the number of BUSY cycles up to and including the `mem_ready` cycle.
- **Back-to-back.** A new strobe can be accepted at the same edge that `done` is asserted for, i.e. the cycle `done` is high is IDLE.
- **Timeout.** `bus_err` is asserted in the cycle after the (`TIMEOUT`+1)th BUSY cycle without `mem_ready`.
- **Protocol.** `mem_ready` outside BUSY is ignored.

## Test plan
- Reset, then hold `clr_n`=1 with no strobes → `ir`=32'h00000013, `mdr`=0, `mem_req`=0, `stall`=0 for 10 cycles.
- Fetch, `pc`=0x100, memory ready on first cycle → `mem_addr`=0x40, `mem_be`=4'hF, `ir`=`mem_rdata`=0x00A00093 two cycles after the strobe; `stall` high 1 cycle; `done` pulses once.
- LB `addr`=0x203, `mem_rdata`=0x80FF_1234 with 3 wait cycles → `stall` high 4 cycles, `mdr`=0xFFFF_FF80. Repeat as LBU → `mdr`=0x0000_0080. Repeat as LH `addr`=0x202 → `mdr`=0xFFFF_80FF.
- SB `addr`=0x11, `rs2`=0x1234_56AB → `mem_we`=1, `mem_be`=4'b0010, `mem_wdata`=0xABAB_ABAB held until `mem_ready`. SH `addr`=0x12 → `mem_be`=4'b1100, `mem_wdata`=0x56AB_56AB.
- SW at `addr`=0x6, and LH at `addr`=0x5 → no `mem_req`, `misalign` pulses once, `mdr` unchanged. Fetch and load strobed together → only the load is issued.
- `TIMEOUT`=4, memory never ready → `bus_err` pulses, `ir` unchanged, state returns to IDLE. Reset asserted in the 2nd BUSY cycle → `mem_req`=0 next cycle, no `done`.
